// File: rtl/scm_arb_pkg.sv
// Shared constants and the round-robin pick function used by both SCM port arbiters.
// rr_pick works on a fixed maximum width so one definition serves any N_PORTS <= MAX_PORTS.
package scm_arb_pkg;

  localparam int N_PORTS_DEF = 4;
  localparam int PORT_IDX_W  = $clog2(N_PORTS_DEF);
  localparam int MAX_PORTS   = 16;
  localparam int MAX_IDX_W   = 4;

  // Returns {valid, index} of the first set bit of req at or after ptr, wrapping at n.
  function automatic logic [MAX_IDX_W:0] rr_pick(
    input logic [MAX_PORTS-1:0] req,
    input logic [MAX_IDX_W-1:0] ptr,
    input int                   n
  );
    logic [MAX_IDX_W:0] res;
    int                 idx;
    res = '0;
    // Walk offsets from farthest to nearest so the nearest candidate wins.
    for (int i = MAX_PORTS - 1; i >= 0; i--) begin
      if (i < n) begin
        idx = (int'(ptr) + i) % n;
        if (req[idx[MAX_IDX_W-1:0]]) begin
          res = {1'b1, idx[MAX_IDX_W-1:0]};
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/scm_rr_pick.sv
// Round-robin selector with its pointer register: combinational one-hot grant, pointer
// moves past the winner on the clock edge. No backpressure; an ungranted request simply waits.
module scm_rr_pick
  import scm_arb_pkg::*;
#(
  parameter int N_PORTS = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_PORTS-1:0] req,
  output logic [N_PORTS-1:0] gnt
);

  logic [MAX_IDX_W-1:0] ptr_q;
  logic [MAX_IDX_W-1:0] ptr_d;
  logic [MAX_PORTS-1:0] req_ext;
  logic [MAX_IDX_W:0]   pick;
  logic                 any;

  always_comb begin
    req_ext                = '0;
    req_ext[N_PORTS-1:0]   = req;
    pick                   = rr_pick(req_ext, ptr_q, N_PORTS);
    any                    = pick[MAX_IDX_W];
    gnt                    = '0;
    for (int k = 0; k < N_PORTS; k++) begin
      gnt[k] = any && (pick[MAX_IDX_W-1:0] == MAX_IDX_W'(k));
    end
    ptr_d = ptr_q;
    if (any) begin
      ptr_d = (pick[MAX_IDX_W-1:0] == MAX_IDX_W'(N_PORTS - 1)) ? '0
                                                              : pick[MAX_IDX_W-1:0] + MAX_IDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/scm_port_arbiter.sv
// Shares a 1R/1W register file among N_PORTS requesters; grant is same-cycle, read data one cycle later.
// Requesters wait (hold) until granted; same-address write data is forwarded to a colliding read.
module scm_port_arbiter
  import scm_arb_pkg::*;
#(
  parameter int N_PORTS    = 4,
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 64
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [N_PORTS-1:0]           req_i,
  input  logic [N_PORTS-1:0]           we_i,
  input  logic [N_PORTS*ADDR_WIDTH-1:0] addr_i,
  input  logic [N_PORTS*DATA_WIDTH-1:0] wdata_i,
  output logic [N_PORTS-1:0]           gnt_o,
  output logic [N_PORTS-1:0]           r_valid_o,
  output logic [DATA_WIDTH-1:0]        r_rdata_o,
  output logic                         rf_read_en_o,
  output logic [ADDR_WIDTH-1:0]        rf_read_addr_o,
  input  logic [DATA_WIDTH-1:0]        rf_read_data_i,
  output logic                         rf_write_en_o,
  output logic [ADDR_WIDTH-1:0]        rf_write_addr_o,
  output logic [DATA_WIDTH-1:0]        rf_write_data_o
);

  logic [N_PORTS-1:0]    rd_req;
  logic [N_PORTS-1:0]    wr_req;
  logic [N_PORTS-1:0]    rd_gnt;
  logic [N_PORTS-1:0]    wr_gnt;
  logic                  collide;
  logic [N_PORTS-1:0]    r_valid_q;
  logic                  byp_q;
  logic [DATA_WIDTH-1:0] byp_dat_q;

  assign rd_req = req_i & ~we_i;
  assign wr_req = req_i & we_i;

  scm_rr_pick #(.N_PORTS(N_PORTS)) u_rd_pick (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (rd_req),
    .gnt   (rd_gnt)
  );

  scm_rr_pick #(.N_PORTS(N_PORTS)) u_wr_pick (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (wr_req),
    .gnt   (wr_gnt)
  );

  assign gnt_o         = rd_gnt | wr_gnt;
  assign rf_read_en_o  = |rd_gnt;
  assign rf_write_en_o = |wr_gnt;

  always_comb begin
    rf_read_addr_o  = '0;
    rf_write_addr_o = '0;
    rf_write_data_o = '0;
    for (int k = 0; k < N_PORTS; k++) begin
      if (rd_gnt[k]) begin
        rf_read_addr_o = addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
      end
      if (wr_gnt[k]) begin
        rf_write_addr_o = addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
        rf_write_data_o = wdata_i[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Memory read returns pre-write contents on a same-cycle collision, so the write data is kept.
  assign collide = rf_read_en_o && rf_write_en_o && (rf_read_addr_o == rf_write_addr_o);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid_q <= '0;
      byp_q     <= 1'b0;
      byp_dat_q <= '0;
    end else begin
      r_valid_q <= rd_gnt;
      byp_q     <= collide;
      if (collide) begin
        byp_dat_q <= rf_write_data_o;
      end
    end
  end

  assign r_valid_o = r_valid_q;

  always_comb begin
    r_rdata_o = '0;
    if (|r_valid_q) begin
      r_rdata_o = byp_q ? byp_dat_q : rf_read_data_i;
    end
  end

endmodule

// File: tb/tb_scm_port_arbiter.sv
// Bench for scm_port_arbiter: directed scenarios plus randomized hold-until-granted traffic
// against a transaction-level model (memory array, round-robin pointers as integers).
module tb_scm_port_arbiter;
  import scm_arb_pkg::*;

  localparam int NP    = 4;
  localparam int AW    = 5;
  localparam int DW    = 64;
  localparam int DEPTH = 32;

  logic                 clk   = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 load  = 1'b0;
  logic [NP-1:0]        req_i = '0;
  logic [NP-1:0]        we_i  = '0;
  logic [NP*AW-1:0]     addr_i  = '0;
  logic [NP*DW-1:0]     wdata_i = '0;
  logic [NP-1:0]        gnt_o;
  logic [NP-1:0]        r_valid_o;
  logic [DW-1:0]        r_rdata_o;
  logic                 rf_read_en_o;
  logic [AW-1:0]        rf_read_addr_o;
  logic [DW-1:0]        rf_read_data_i;
  logic                 rf_write_en_o;
  logic [AW-1:0]        rf_write_addr_o;
  logic [DW-1:0]        rf_write_data_o;

  scm_port_arbiter #(.N_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_i           (req_i),
    .we_i            (we_i),
    .addr_i          (addr_i),
    .wdata_i         (wdata_i),
    .gnt_o           (gnt_o),
    .r_valid_o       (r_valid_o),
    .r_rdata_o       (r_rdata_o),
    .rf_read_en_o    (rf_read_en_o),
    .rf_read_addr_o  (rf_read_addr_o),
    .rf_read_data_i  (rf_read_data_i),
    .rf_write_en_o   (rf_write_en_o),
    .rf_write_addr_o (rf_write_addr_o),
    .rf_write_data_o (rf_write_data_o)
  );

  always #5 clk = ~clk;

  // Register-file stand-in: 1-cycle read latency, read returns the pre-write contents.
  logic [DW-1:0] scm_mem [DEPTH];
  logic [DW-1:0] scm_rd_q;
  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < DEPTH; i++) scm_mem[i] <= DW'(32'hA0 + i);
    end else begin
      if (rf_write_en_o) scm_mem[rf_write_addr_o] <= rf_write_data_o;
    end
    if (rf_read_en_o) scm_rd_q <= scm_mem[rf_read_addr_o];
  end
  assign rf_read_data_i = scm_rd_q;

  // Reference model state.
  logic [DW-1:0] m_mem [DEPTH];
  int            m_rd_ptr;
  int            m_wr_ptr;
  logic [NP-1:0] exp_vld;
  logic [DW-1:0] exp_dat;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic int rr_first(input logic [NP-1:0] cand, input int ptr);
    int k;
    for (int o = 0; o < NP; o++) begin
      k = (ptr + o) % NP;
      if (cand[k[1:0]]) return k;
    end
    return -1;
  endfunction

  function automatic logic [NP*AW-1:0] mk_addr(input int a0, input int a1, input int a2, input int a3);
    return {AW'(a3), AW'(a2), AW'(a1), AW'(a0)};
  endfunction

  function automatic logic [NP*DW-1:0] mk_wd(input int k, input logic [DW-1:0] v);
    logic [NP*DW-1:0] r;
    r = '0;
    r[k*DW +: DW] = v;
    return r;
  endfunction

  // Called at a falling edge: check the response due now, apply new inputs, check the
  // combinational grant/rf outputs, advance the model, and return at the next falling edge.
  task automatic cycle(input logic [NP-1:0] rq, input logic [NP-1:0] w,
                       input logic [NP*AW-1:0] ad, input logic [NP*DW-1:0] wd,
                       output logic [NP-1:0] granted);
    int            rk, wk;
    logic [NP-1:0] eg;
    logic [AW-1:0] ra, wa;
    logic [DW-1:0] wv;
    chk("r_valid", DW'(r_valid_o), DW'(exp_vld));
    chk("r_rdata", r_rdata_o, exp_dat);
    req_i = rq; we_i = w; addr_i = ad; wdata_i = wd;
    #1;
    rk = rr_first(rq & ~w, m_rd_ptr);
    wk = rr_first(rq & w, m_wr_ptr);
    eg = '0; ra = '0; wa = '0; wv = '0;
    if (rk >= 0) begin
      eg = eg | (NP'(1) << rk);
      ra = ad[rk*AW +: AW];
    end
    if (wk >= 0) begin
      eg = eg | (NP'(1) << wk);
      wa = ad[wk*AW +: AW];
      wv = wd[wk*DW +: DW];
    end
    chk("gnt", DW'(gnt_o), DW'(eg));
    chk("rd_en", DW'(rf_read_en_o), DW'(rk >= 0));
    chk("wr_en", DW'(rf_write_en_o), DW'(wk >= 0));
    chk("rd_addr", DW'(rf_read_addr_o), DW'(ra));
    chk("wr_addr", DW'(rf_write_addr_o), DW'(wa));
    chk("wr_data", rf_write_data_o, wv);
    // A reader granted alongside a same-address writer must see the new value.
    if (wk >= 0) begin
      m_mem[wa] = wv;
      m_wr_ptr  = (wk + 1) % NP;
    end
    if (rk >= 0) begin
      exp_vld  = NP'(1) << rk;
      exp_dat  = m_mem[ra];
      m_rd_ptr = (rk + 1) % NP;
    end else begin
      exp_vld = '0;
      exp_dat = '0;
    end
    granted = eg;
    @(negedge clk);
  endtask

  task automatic do_reset();
    req_i = '0; we_i = '0; addr_i = '0; wdata_i = '0;
    rst_n = 1'b0;
    #1;
    chk("rst_valid", DW'(r_valid_o), '0);
    chk("rst_rdata", r_rdata_o, '0);
    chk("rst_gnt", DW'(gnt_o), '0);
    chk("rst_rd_en", DW'(rf_read_en_o), '0);
    m_rd_ptr = 0; m_wr_ptr = 0; exp_vld = '0; exp_dat = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [NP-1:0] g;
  logic          p_req [NP];
  logic          p_we  [NP];
  logic [AW-1:0] p_addr[NP];
  logic [DW-1:0] p_wd  [NP];
  int            p_wt  [NP];

  initial begin
    for (int i = 0; i < DEPTH; i++) m_mem[i] = DW'(32'hA0 + i);
    @(negedge clk);
    load = 1'b1;
    do_reset();
    load = 1'b0;

    // 1: single read, port 2, addr 5
    cycle(4'b0100, 4'b0000, mk_addr(0, 0, 5, 0), '0, g);
    chk("t1_valid", DW'(r_valid_o), DW'(4'b0100));
    chk("t1_rdata", r_rdata_o, 64'hA5);

    // 2: all ports read continuously; strict rotation, a response every cycle
    do_reset();
    for (int c = 0; c < 8; c++) begin
      cycle(4'b1111, 4'b0000, mk_addr(10, 11, 12, 13), '0, g);
      chk("t2_order", DW'(g), DW'(NP'(1) << (c % NP)));
      chk("t2_noidle", DW'(|r_valid_o), DW'(1'b1));
    end

    // 3: same-address write/read collision is forwarded
    do_reset();
    cycle(4'b0011, 4'b0001, mk_addr(3, 3, 0, 0), mk_wd(0, 64'h1234), g);
    chk("t3_valid", DW'(r_valid_o), DW'(4'b0010));
    chk("t3_fwd", r_rdata_o, 64'h1234);

    // 4: different addresses read memory; later read sees the new value
    cycle(4'b0011, 4'b0001, mk_addr(3, 4, 0, 0), mk_wd(0, 64'h5678), g);
    chk("t4_old", r_rdata_o, 64'hA4);
    cycle(4'b0100, 4'b0000, mk_addr(0, 0, 3, 0), '0, g);
    chk("t4_new", r_rdata_o, 64'h5678);

    // 5: two writers and a reader; write pointer wraps back to 0
    do_reset();
    cycle(4'b1011, 4'b1010, mk_addr(7, 8, 0, 9), mk_wd(1, 64'h11) | mk_wd(3, 64'h33), g);
    cycle(4'b1000, 4'b1000, mk_addr(0, 0, 0, 9), mk_wd(3, 64'h33), g);
    cycle(4'b0011, 4'b0011, mk_addr(20, 21, 0, 0), mk_wd(0, 64'h20) | mk_wd(1, 64'h21), g);
    chk("t5_wrap", DW'(g), DW'(4'b0001));

    // 6: reset right after a read grant drops the response; port 3 wins first try after
    cycle(4'b0100, 4'b0000, mk_addr(0, 0, 6, 0), '0, g);
    do_reset();
    chk("t6_dropped", DW'(r_valid_o), '0);
    cycle(4'b1000, 4'b0000, mk_addr(0, 0, 0, 9), '0, g);
    chk("t6_first", DW'(g), DW'(4'b1000));

    // Random traffic: requesters hold until granted, may occasionally give up
    for (int k = 0; k < NP; k++) begin
      p_req[k] = 1'b0; p_we[k] = 1'b0; p_addr[k] = '0; p_wd[k] = '0; p_wt[k] = 0;
    end
    for (int c = 0; c < 600; c++) begin
      logic [NP-1:0]    rq, w;
      logic [NP*AW-1:0] ad;
      logic [NP*DW-1:0] wd;
      for (int k = 0; k < NP; k++) begin
        if (p_req[k]) begin
          if ($urandom_range(7) == 0) begin
            p_req[k] = 1'b0;
            p_wt[k]  = 0;
          end
        end else if ($urandom_range(1) == 1) begin
          p_req[k]  = 1'b1;
          p_we[k]   = 1'($urandom_range(1));
          p_addr[k] = AW'($urandom_range(7));
          p_wd[k]   = {$urandom, $urandom};
          p_wt[k]   = 0;
        end
        rq[k] = p_req[k];
        w[k]  = p_we[k];
        ad[k*AW +: AW] = p_addr[k];
        wd[k*DW +: DW] = p_wd[k];
      end
      cycle(rq, w, ad, wd, g);
      for (int k = 0; k < NP; k++) begin
        if (p_req[k]) begin
          p_wt[k]++;
          if (g[k]) begin
            chk("starve", DW'(p_wt[k] <= NP), DW'(1'b1));
            p_req[k] = 1'b0;
            p_wt[k]  = 0;
          end
        end
      end
    end
    cycle('0, '0, '0, '0, g);
    chk("final_valid", DW'(r_valid_o), DW'(exp_vld));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
